alarm_zone_controller: RTL and testbench
========================================

# alarm_zone_controller

Parametrised successor to the two-sensor alarm FSM: arms, disarms and triggers over `N_ZONES` sensor zones, each independently enabled and set to instant or entry-delayed mode. Adds an exit delay, a programmable siren cut-off and a wrong-key lockout. The block consumes the key checker's status code, drives the siren and produces the status word for the serial status transmitter.

## Interface

**Parameters**
- `N_ZONES`, 2: number of sensor zones (1..8).
- `CNT_W`, 18: width of the shared delay counter.
- `EXIT_DELAY`, 15000: cycles from arming to armed. 0 is treated as 1.
- `ENTRY_DELAY`, 15000: cycles from a delayed-zone trip to alarm. 0 is treated as 1.
- `SIREN_TIME`, 60000: cycles the siren sounds. 0 means the siren sounds until disarmed.
- `MAX_BAD_KEYS`, 3: consecutive wrong keys that force an alarm (≥1).

**Ports**
- `CLK` in 1: single clock, the low-speed oscillator.
- `RST_N` in 1: asynchronous, active-low reset.
- `key_status` in 2: 0 = KEY_OK, 2 = KEY_ERROR, 3 = NO_KEY. Code 1 is treated as NO_KEY.
- `key_rst` out 1: combinational; high when `key_status` is KEY_OK or KEY_ERROR, which consumes the code.
- `sensor_in` in N_ZONES: active-high zone sensors, already synchronised.
- `zone_enable` in N_ZONES: 0 bypasses the zone.
- `zone_delayed` in N_ZONES: 1 = entry-delay zone, 0 = instant zone.
- `siren_out` out 1: siren drive.
- `armed` out 1: high in every state except INACTIVO.
- `state` out 3: current state code.
- `alarm_zones` out N_ZONES: sticky record of the zones that tripped.
- `status_msg` out N_ZONES+2: {`sensor_in & zone_enable`, `siren_out`, `armed`}.

## Operation

**States:** INACTIVO = 0, SALIDA = 1, ARMADO = 2, ESPERA = 3, ALARMA = 4. Codes 5–7 recover to INACTIVO on the next clock.

**Tripped zones**
- `trip_i = sensor_in & zone_enable & ~zone_delayed`
- `trip_d = sensor_in & zone_enable & zone_delayed`

**Priority in every state:** KEY_OK first, then KEY_ERROR lockout, then sensors, then counter expiry.

**Transitions**
- INACTIVO
  - KEY_OK → SALIDA; load the counter with EXIT_DELAY; clear `alarm_zones`.
- SALIDA
  - KEY_OK → INACTIVO.
  - Counter expiry → ARMADO.
  - Sensors are ignored.
- ARMADO
  - KEY_OK → INACTIVO.
  - Any `trip_i` → ALARMA.
  - Otherwise any `trip_d` → ESPERA; load the counter with ENTRY_DELAY.
  - Tripping bits are ORed into `alarm_zones`.
- ESPERA
  - KEY_OK → INACTIVO.
  - Any `trip_i` → ALARMA.
  - Counter expiry → ALARMA.
  - New trips are ORed into `alarm_zones`.
- ALARMA
  - KEY_OK → INACTIVO.
  - The counter is loaded with SIREN_TIME on entry.
  - `siren_out` is high while the counter is non-zero, or always when SIREN_TIME = 0.
  - After cut-off the block stays in ALARMA, silent, with `armed` = 1.

**Wrong-key lockout**
- Every KEY_ERROR outside ALARMA increments `bad_cnt`; KEY_OK clears it.
- When `bad_cnt` reaches MAX_BAD_KEYS the FSM goes to ALARMA from any state and `bad_cnt` clears.
- KEY_ERROR in ALARMA is ignored.

**Latching:** `alarm_zones` holds its value through INACTIVO so the last cause stays readable.

## Timing

**Reset values:** state INACTIVO; `siren_out`, `armed`, `alarm_zones`, counter and `bad_cnt` all 0. `key_rst` follows `key_status` combinationally, even during reset.

**Latency**
- The state register updates on the rising `CLK` edge after the qualifying input.
- `siren_out` and `armed` are decoded from registered state, so they change in the same cycle as `state`.

**Counter**
- The counter decrements once per cycle in SALIDA, ESPERA and ALARMA.
- With no other event, SALIDA and ESPERA last exactly N cycles for a delay of N. Expiry is taken when the counter equals 1.

**Simultaneous events**
- KEY_OK on the expiry cycle → INACTIVO.
- KEY_ERROR that completes the lockout on the same cycle as a trip → ALARMA, with `alarm_zones` updated.

**Key codes:** a KEY_OK or KEY_ERROR code is acted on exactly once, because `key_rst` is returned in the same cycle.

**Reset mid-operation:** `RST_N` low forces every register to its reset value asynchronously, including during ALARMA with the siren on.

## Structure

- Package `alarm_pkg` holds:
  - state codes INACTIVO..ALARMA;
  - KEY_OK, KEY_ERROR and NO_KEY;
  - a status-word width function.
- Sub-module `delay_counter` is a loadable down-counter, CNT_W wide, with `load`, `value`, `dec_en` and a `one` flag. One instance is shared by all three delays.

## Test plan

1. **Arm and exit delay.** EXIT_DELAY=4: KEY_OK in INACTIVO → SALIDA for exactly 4 cycles, then ARMADO; `armed`=1 throughout, `siren_out`=0.
2. **Instant zone.** N_ZONES=2, zone 0 instant, enabled, in ARMADO: `sensor_in`=01 → ALARMA next cycle, `siren_out`=1, `alarm_zones`=01.
3. **Entry delay.** ENTRY_DELAY=5, zone 1 delayed: trip → ESPERA.
   - KEY_OK at cycle 3 → INACTIVO, `siren_out` never high.
   - Repeat without the key → ALARMA after exactly 5 cycles.
4. **Bypass and siren cut-off.**
   - `zone_enable`=10 with zone 0 sensor active in ARMADO → stays ARMADO.
   - SIREN_TIME=3 in ALARMA → `siren_out` high for exactly 3 cycles, then low while `state`=4.
5. **Lockout.** MAX_BAD_KEYS=3: three KEY_ERROR codes in INACTIVO → ALARMA after the third, with `key_rst` pulsed each time. A KEY_OK between errors resets the count.
6. **Collisions.**
   - KEY_OK on the ESPERA expiry cycle → INACTIVO.
   - `RST_N` low during ALARMA → all outputs 0 immediately, without waiting for `CLK`.

Source files
------------

// File: rtl/alarm_zone_controller_pkg.sv
// Shared constants for the alarm zone controller: FSM state codes, key checker
// status codes and the status-word width helper.
package alarm_pkg;

    localparam logic [2:0] INACTIVO = 3'd0;
    localparam logic [2:0] SALIDA   = 3'd1;
    localparam logic [2:0] ARMADO   = 3'd2;
    localparam logic [2:0] ESPERA   = 3'd3;
    localparam logic [2:0] ALARMA   = 3'd4;

    localparam logic [1:0] KEY_OK    = 2'd0;
    localparam logic [1:0] KEY_ERROR = 2'd2;
    localparam logic [1:0] NO_KEY    = 2'd3;

    // Status word is {zone sensors, siren, armed}.
    function automatic int status_w(input int n_zones);
        return n_zones + 2;
    endfunction

endpackage

// File: rtl/alarm_zone_controller_if.sv
// Bundles the key checker, sensor, siren and status signals of the alarm
// zone controller. The controller itself connects through the slave modport.
interface alarm_zone_controller_if #(
    parameter int N_ZONES = 2
);

    logic [1:0]                                   key_status;
    logic                                         key_rst;
    logic [N_ZONES-1:0]                           sensor_in;
    logic [N_ZONES-1:0]                           zone_enable;
    logic [N_ZONES-1:0]                           zone_delayed;
    logic                                         siren_out;
    logic                                         armed;
    logic [2:0]                                   state;
    logic [N_ZONES-1:0]                           alarm_zones;
    logic [alarm_pkg::status_w(N_ZONES)-1:0]      status_msg;

    modport master (
        output key_status, sensor_in, zone_enable, zone_delayed,
        input  key_rst, siren_out, armed, state, alarm_zones, status_msg
    );

    modport slave (
        input  key_status, sensor_in, zone_enable, zone_delayed,
        output key_rst, siren_out, armed, state, alarm_zones, status_msg
    );

endinterface

// File: rtl/alarm_zone_controller_delay_counter.sv
// Loadable down-counter shared by the exit, entry and siren delays. It stops
// at zero so a finished siren period stays finished.
module delay_counter #(
    parameter int CNT_W = 18
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec_en,
    output logic             one,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (dec_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign one   = (r_count == CNT_W'(1));
    assign count = r_count;

endmodule

// File: rtl/alarm_zone_controller.sv
// Multi-zone alarm FSM: exit/entry delays, timed siren and wrong-key lockout,
// driving the siren and the status word for the serial transmitter.
module alarm_zone_controller #(
    parameter int N_ZONES      = 2,
    parameter int CNT_W        = 18,
    parameter int EXIT_DELAY   = 15000,
    parameter int ENTRY_DELAY  = 15000,
    parameter int SIREN_TIME   = 60000,
    parameter int MAX_BAD_KEYS = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    alarm_zone_controller_if.slave  bus
);

    import alarm_pkg::*;

    localparam int BAD_W = $clog2(MAX_BAD_KEYS + 1);
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'((EXIT_DELAY  == 0) ? 1 : EXIT_DELAY);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'((ENTRY_DELAY == 0) ? 1 : ENTRY_DELAY);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME);

    logic [2:0]         r_state;
    logic [N_ZONES-1:0] r_alarm_zones;
    logic [BAD_W-1:0]   r_bad_cnt;

    logic [2:0]         w_next_state;
    logic [N_ZONES-1:0] w_next_zones;
    logic [BAD_W-1:0]   w_next_bad;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_dec_en;
    logic               w_one;
    logic [CNT_W-1:0]   w_count;
    logic               w_key_ok;
    logic               w_key_err;
    logic               w_lockout;
    logic               w_state_ok;
    logic [N_ZONES-1:0] w_trip_i;
    logic [N_ZONES-1:0] w_trip_d;
    logic               w_siren;
    logic               w_armed;

    assign w_key_ok   = (bus.key_status == KEY_OK);
    assign w_key_err  = (bus.key_status == KEY_ERROR);
    assign w_trip_i   = bus.sensor_in & bus.zone_enable & ~bus.zone_delayed;
    assign w_trip_d   = bus.sensor_in & bus.zone_enable &  bus.zone_delayed;
    assign w_state_ok = (r_state <= ALARMA);
    assign w_lockout  = w_key_err && w_state_ok && (r_state != ALARMA)
                        && ((int'(r_bad_cnt) + 1) >= MAX_BAD_KEYS);
    assign w_dec_en   = (r_state == SALIDA) || (r_state == ESPERA) || (r_state == ALARMA);

    // NOTE: every variable gets a default at the top of the block so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_zones = r_alarm_zones;
        w_next_bad   = r_bad_cnt;
        w_load       = 1'b0;
        w_load_val   = SIREN_LD;

        if (w_key_ok) begin
            w_next_bad = '0;
            if (r_state == INACTIVO) begin
                w_next_state = SALIDA;
                w_next_zones = '0;
                w_load       = 1'b1;
                w_load_val   = EXIT_LD;
            end else begin
                w_next_state = INACTIVO;
            end
        end else begin
            case (r_state)
                INACTIVO: ;
                SALIDA: begin
                    if (w_one) w_next_state = ARMADO;
                end
                ARMADO: begin
                    w_next_zones = r_alarm_zones | w_trip_i | w_trip_d;
                    if (|w_trip_i) begin
                        w_next_state = ALARMA;
                    end else if (|w_trip_d) begin
                        w_next_state = ESPERA;
                        w_load       = 1'b1;
                        w_load_val   = ENTRY_LD;
                    end
                end
                ESPERA: begin
                    w_next_zones = r_alarm_zones | w_trip_i | w_trip_d;
                    if ((|w_trip_i) || w_one) w_next_state = ALARMA;
                end
                ALARMA: ;
                default: w_next_state = INACTIVO;
            endcase

            // Lockout overrides the sensor decision but keeps its zone record.
            if (w_key_err && w_state_ok && (r_state != ALARMA)) begin
                if (w_lockout) begin
                    w_next_state = ALARMA;
                    w_next_bad   = '0;
                end else begin
                    w_next_bad = r_bad_cnt + 1'b1;
                end
            end

            if ((w_next_state == ALARMA) && (r_state != ALARMA)) begin
                w_load     = 1'b1;
                w_load_val = SIREN_LD;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= INACTIVO;
            r_alarm_zones <= '0;
            r_bad_cnt     <= '0;
        end else begin
            r_state       <= w_next_state;
            r_alarm_zones <= w_next_zones;
            r_bad_cnt     <= w_next_bad;
        end
    end

    delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load   (w_load),
        .value  (w_load_val),
        .dec_en (w_dec_en),
        .one    (w_one),
        .count  (w_count)
    );

    assign w_siren = (r_state == ALARMA) && ((SIREN_TIME == 0) || (w_count != '0));
    assign w_armed = (r_state != INACTIVO);

    assign bus.key_rst     = w_key_ok || w_key_err;
    assign bus.siren_out   = w_siren;
    assign bus.armed       = w_armed;
    assign bus.state       = r_state;
    assign bus.alarm_zones = r_alarm_zones;
    assign bus.status_msg  = {bus.sensor_in & bus.zone_enable, w_siren, w_armed};

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Table-driven bench for alarm_zone_controller with a scoreboard queue of
// expected post-edge outputs, plus hand-written reset sequences.
module tb_alarm_zone_controller;

    import alarm_pkg::*;

    localparam int NZ = 2;

    typedef struct {
        logic [1:0]    key;
        logic [NZ-1:0] sens;
        logic [NZ-1:0] en;
        logic [NZ-1:0] dly;
        logic [2:0]    st;
        logic          siren;
        logic [NZ-1:0] zones;
    } vec_t;

    typedef struct {
        logic [2:0]    st;
        logic          siren;
        logic          armed;
        logic [NZ-1:0] zones;
        logic [NZ+1:0] msg;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 CLK = ~CLK;

    alarm_zone_controller_if #(.N_ZONES(NZ)) bus ();

    alarm_zone_controller #(
        .N_ZONES      (NZ),
        .CNT_W        (18),
        .EXIT_DELAY   (4),
        .ENTRY_DELAY  (5),
        .SIREN_TIME   (3),
        .MAX_BAD_KEYS (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Zone 0 is instant, zone 1 entry-delayed throughout.
    task automatic add(input logic [1:0] key, input logic [NZ-1:0] sens, input logic [NZ-1:0] en,
                       input logic [2:0] st, input logic siren, input logic [NZ-1:0] zones);
        vec_t v;
        v.key = key; v.sens = sens; v.en = en; v.dly = 2'b10;
        v.st = st; v.siren = siren; v.zones = zones;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [2:0] st, input logic siren, input logic [NZ-1:0] zones);
        for (int k = 0; k < n; k++) add(NO_KEY, 2'b00, 2'b11, st, siren, zones);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        bus.key_status   = v.key;
        bus.sensor_in    = v.sens;
        bus.zone_enable  = v.en;
        bus.zone_delayed = v.dly;
        e.st    = v.st;
        e.siren = v.siren;
        e.armed = (v.st != INACTIVO);
        e.zones = v.zones;
        e.msg   = {v.sens & v.en, v.siren, e.armed};
        sb.push_back(e);
        #1;
        check($sformatf("v%0d key_rst", idx), 32'(bus.key_rst),
              32'((v.key == KEY_OK) || (v.key == KEY_ERROR)));
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d state", idx),       32'(bus.state),       32'(e.st));
        check($sformatf("v%0d siren_out", idx),   32'(bus.siren_out),   32'(e.siren));
        check($sformatf("v%0d armed", idx),       32'(bus.armed),       32'(e.armed));
        check($sformatf("v%0d alarm_zones", idx), 32'(bus.alarm_zones), 32'(e.zones));
        check($sformatf("v%0d status_msg", idx),  32'(bus.status_msg),  32'(e.msg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Arm, exit delay of 4 (sensor ignored in SALIDA), instant zone, siren cut-off.
        add(KEY_OK, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add(NO_KEY, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add(NO_KEY, 2'b01, 2'b11, SALIDA, 0, 2'b00);
        add(NO_KEY, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add(NO_KEY, 2'b00, 2'b11, ARMADO, 0, 2'b00);
        add(NO_KEY, 2'b01, 2'b11, ALARMA, 1, 2'b01);
        add_n(2, ALARMA, 1, 2'b01);
        add_n(2, ALARMA, 0, 2'b01);
        add(KEY_OK, 2'b00, 2'b11, INACTIVO, 0, 2'b01);
        // Bypassed zone, then entry delay cancelled by key on its third cycle.
        add(KEY_OK, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add_n(3, SALIDA, 0, 2'b00);
        add_n(1, ARMADO, 0, 2'b00);
        add(NO_KEY, 2'b01, 2'b10, ARMADO, 0, 2'b00);
        add(NO_KEY, 2'b10, 2'b11, ESPERA, 0, 2'b10);
        add_n(2, ESPERA, 0, 2'b10);
        add(KEY_OK, 2'b00, 2'b11, INACTIVO, 0, 2'b10);
        // Entry delay of 5 running out.
        add(KEY_OK, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add_n(3, SALIDA, 0, 2'b00);
        add_n(1, ARMADO, 0, 2'b00);
        add(NO_KEY, 2'b10, 2'b11, ESPERA, 0, 2'b10);
        add_n(4, ESPERA, 0, 2'b10);
        add_n(1, ALARMA, 1, 2'b10);
        add(KEY_OK, 2'b00, 2'b11, INACTIVO, 0, 2'b10);
        // Lockout: KEY_OK clears the count, three errors alarm, errors in ALARMA ignored.
        add(KEY_ERROR, 2'b00, 2'b11, INACTIVO, 0, 2'b10);
        add(KEY_ERROR, 2'b00, 2'b11, INACTIVO, 0, 2'b10);
        add(KEY_OK,    2'b00, 2'b11, SALIDA,   0, 2'b00);
        add(KEY_OK,    2'b00, 2'b11, INACTIVO, 0, 2'b00);
        add(KEY_ERROR, 2'b00, 2'b11, INACTIVO, 0, 2'b00);
        add(KEY_ERROR, 2'b00, 2'b11, INACTIVO, 0, 2'b00);
        add(KEY_ERROR, 2'b00, 2'b11, ALARMA,   1, 2'b00);
        add(KEY_ERROR, 2'b00, 2'b11, ALARMA,   1, 2'b00);
        add_n(1, ALARMA, 1, 2'b00);
        add_n(1, ALARMA, 0, 2'b00);
        for (int k = 0; k < 3; k++) add(KEY_ERROR, 2'b00, 2'b11, ALARMA, 0, 2'b00);
        add(KEY_OK, 2'b00, 2'b11, INACTIVO, 0, 2'b00);
        // Lockout completing on the same cycle as a delayed-zone trip.
        add(KEY_OK, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add_n(3, SALIDA, 0, 2'b00);
        add_n(1, ARMADO, 0, 2'b00);
        add(KEY_ERROR, 2'b00, 2'b11, ARMADO, 0, 2'b00);
        add(KEY_ERROR, 2'b00, 2'b11, ARMADO, 0, 2'b00);
        add(KEY_ERROR, 2'b10, 2'b11, ALARMA, 1, 2'b10);
        add(KEY_OK,    2'b00, 2'b11, INACTIVO, 0, 2'b10);
        // KEY_OK on the ESPERA expiry cycle.
        add(KEY_OK, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add_n(3, SALIDA, 0, 2'b00);
        add_n(1, ARMADO, 0, 2'b00);
        add(NO_KEY, 2'b10, 2'b11, ESPERA, 0, 2'b10);
        add_n(4, ESPERA, 0, 2'b10);
        add(KEY_OK, 2'b00, 2'b11, INACTIVO, 0, 2'b10);
        // Instant trip during ESPERA, leaving the siren on for the reset test.
        add(KEY_OK, 2'b00, 2'b11, SALIDA, 0, 2'b00);
        add_n(3, SALIDA, 0, 2'b00);
        add_n(1, ARMADO, 0, 2'b00);
        add(NO_KEY, 2'b10, 2'b11, ESPERA, 0, 2'b10);
        add(NO_KEY, 2'b01, 2'b11, ALARMA, 1, 2'b11);

        RST_N            = 1'b0;
        bus.key_status   = NO_KEY;
        bus.sensor_in    = '0;
        bus.zone_enable  = '1;
        bus.zone_delayed = 2'b10;
        #12;
        check("reset state",       32'(bus.state),       32'(INACTIVO));
        check("reset siren_out",   32'(bus.siren_out),   32'd0);
        check("reset armed",       32'(bus.armed),       32'd0);
        check("reset alarm_zones", 32'(bus.alarm_zones), 32'd0);
        check("reset key_rst",     32'(bus.key_rst),     32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset in ALARMA with the siren on, away from any clock edge.
        #2;
        bus.sensor_in = '0;
        RST_N = 1'b0;
        #1;
        check("async rst state",       32'(bus.state),       32'(INACTIVO));
        check("async rst siren_out",   32'(bus.siren_out),   32'd0);
        check("async rst armed",       32'(bus.armed),       32'd0);
        check("async rst alarm_zones", 32'(bus.alarm_zones), 32'd0);
        check("async rst status_msg",  32'(bus.status_msg),  32'd0);
        bus.key_status = KEY_OK;
        #1;
        check("key_rst in reset ok", 32'(bus.key_rst), 32'd1);
        @(posedge CLK);
        #1;
        check("state held in reset", 32'(bus.state), 32'(INACTIVO));
        bus.key_status = NO_KEY;
        #1;
        check("key_rst in reset none", 32'(bus.key_rst), 32'd0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
